// File: rtl/bg_layer_gen.sv
// Scrolling tile background layer: phase-sequenced tilemap / tile ROM fetch feeding a
// per-plane pixel shifter. Define BGLAYER_HFLIP_EN to enable per-tile horizontal flip.
module bg_layer_gen #(
    parameter int unsigned PLANES      = 3,  // legal 1..4
    parameter bit          PRIO_EN_DEF = 1'b1
) (
    input  logic                  VCLK,
    input  logic                  RESET,
    input  logic [8:0]            HP,
    input  logic [8:0]            VP,
    input  logic [8:0]            SCRX,
    input  logic [8:0]            SCRY,
    output logic [9:0]            VRAMAD,
    input  logic [15:0]           VRAMDT,
    output logic [13:0]           TILEAD,
    input  logic [8*PLANES-1:0]   TILEDT,
    output logic [3+PLANES:0]     OPIX
);

    typedef enum logic [1:0] {StIdle, StFetch, StReady} fetch_state_e;

    logic [8:0] scrx_q, scry_q;
    logic [8:0] ex, ey, nx;
    logic [2:0] phase;

    fetch_state_e state_q, state_d;
    logic         load_en;

    logic [10:0]             tile_stage_q;
    logic [3:0]              attr_stage_q;   // {priority, palette}
    logic [PLANES-1:0][7:0]  pat_stage_q;
    logic [PLANES-1:0][7:0]  shift_q, shift_d;
    logic [3:0]              attr_q;
    logic                    prio_en_q;
    logic [PLANES-1:0]       pix;
`ifdef BGLAYER_HFLIP_EN
    logic                    hflip_stage_q;
    logic                    hflip_q;
`endif

    assign ex    = HP + scrx_q;
    assign ey    = VP + scry_q;
    assign nx    = ex + 9'd8;
    assign phase = ex[2:0];

    logic unused_bits;
`ifdef BGLAYER_HFLIP_EN
    assign unused_bits = ^{ey[8], nx[8], nx[2:0]};
`else
    assign unused_bits = ^{ey[8], nx[8], nx[2:0], VRAMDT[11]};
`endif

    // Loads are held off after reset until one full phase 0..3 fetch has completed.
    always_ff @(posedge VCLK) begin
        if (RESET) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (phase == 3'd0) state_d = StFetch;
            StFetch: if (phase == 3'd3) state_d = StReady;
            StReady: state_d = StReady;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        load_en = 1'b0;
        if (state_q == StReady && phase == 3'd7) begin
            load_en = 1'b1;
        end
    end

    always_comb begin
        pix = '0;
        for (int p = 0; p < int'(PLANES); p++) begin
`ifdef BGLAYER_HFLIP_EN
            pix[p] = hflip_q ? shift_q[p][0] : shift_q[p][7];
`else
            pix[p] = shift_q[p][7];
`endif
        end
    end

    always_comb begin
        shift_d = shift_q;
        if (load_en) begin
            shift_d = pat_stage_q;
        end else begin
            for (int p = 0; p < int'(PLANES); p++) begin
`ifdef BGLAYER_HFLIP_EN
                shift_d[p] = hflip_q ? {1'b0, shift_q[p][7:1]} : {shift_q[p][6:0], 1'b0};
`else
                shift_d[p] = {shift_q[p][6:0], 1'b0};
`endif
            end
        end
    end

    always_ff @(posedge VCLK) begin
        if (RESET) begin
            scrx_q       <= '0;
            scry_q       <= '0;
            VRAMAD       <= '0;
            TILEAD       <= '0;
            tile_stage_q <= '0;
            attr_stage_q <= '0;
            pat_stage_q  <= '0;
            shift_q      <= '0;
            attr_q       <= '0;
            OPIX         <= '0;
            prio_en_q    <= PRIO_EN_DEF;
`ifdef BGLAYER_HFLIP_EN
            hflip_stage_q <= 1'b0;
            hflip_q       <= 1'b0;
`endif
        end else begin
            // Scroll latches once per line; EX/EY this cycle still use the old values.
            if (HP == 9'd0) begin
                scrx_q <= SCRX;
                scry_q <= SCRY;
            end
            case (phase)
                3'd0: VRAMAD <= {ey[7:3], nx[7:3]};
                3'd1: begin
                    tile_stage_q <= VRAMDT[10:0];
                    attr_stage_q <= {VRAMDT[15], VRAMDT[14:12]};
`ifdef BGLAYER_HFLIP_EN
                    hflip_stage_q <= VRAMDT[11];
`endif
                end
                3'd2: TILEAD <= {tile_stage_q, ey[2:0]};
                3'd3: pat_stage_q <= TILEDT;
                default: ;
            endcase
            shift_q <= shift_d;
            if (load_en) begin
                attr_q <= attr_stage_q;
`ifdef BGLAYER_HFLIP_EN
                hflip_q <= hflip_stage_q;
`endif
            end
            prio_en_q <= prio_en_q;
            OPIX      <= {attr_q[3] & prio_en_q, attr_q[2:0], pix};
        end
    end

endmodule

// File: doc/bg_layer_gen.md
BG_LAYER_GEN -- requirements
Module: bg_layer_gen

Interface
REQ-001 The module SHALL have parameter PLANES, default 3, meaning bitplanes per tile pixel (legal 1..4).
REQ-002 The module SHALL have parameter PRIO_EN_DEF, default 1, meaning the reset value of the priority-pass enable.
REQ-003 The module SHALL have port VCLK, input, 1 bit: pixel clock, the only clock.
REQ-004 The module SHALL have port RESET, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port HP, input, 9 bits: raw horizontal position, incrementing by 1 per VCLK and wrapping 511->0.
REQ-006 The module SHALL have port VP, input, 9 bits: raw vertical position.
REQ-007 The module SHALL have port SCRX, input, 9 bits: horizontal scroll.
REQ-008 The module SHALL have port SCRY, input, 9 bits: vertical scroll.
REQ-009 The module SHALL have port VRAMAD, output, 10 bits: tilemap address {row[4:0], col[4:0]}.
REQ-010 The module SHALL have port VRAMDT, input, 16 bits: tilemap word, valid 1 VCLK after VRAMAD; fields [10:0] tile, [11] hflip, [14:12] palette, [15] priority.
REQ-011 The module SHALL have port TILEAD, output, 14 bits: tile ROM address {tile[10:0], line[2:0]}.
REQ-012 The module SHALL have port TILEDT, input, 8*PLANES bits: plane p in [8p+7:8p], valid 1 VCLK after TILEAD.
REQ-013 The module SHALL have port OPIX, output, 4+PLANES bits: {priority, palette[2:0], pixel[PLANES-1:0]}; pixel 0 means transparent.

Function
REQ-014 SCRX and SCRY SHALL be captured into internal registers only on the VCLK edge where HP==0, so mid-line writes take effect on the next line.
REQ-015 Effective coordinates SHALL be EX=(HP+SCRXr) mod 512 and EY=(VP+SCRYr) mod 512, with all 9-bit adds truncated.
REQ-016 The fetch sequencer SHALL use phase=EX[2:0] and SHALL always fetch the next tile column NX=EX+8.
REQ-017 Phase 0: VRAMAD SHALL be driven to {EY[7:3], NX[7:3]} and held until the next phase 0.
REQ-018 Phase 1: VRAMDT SHALL be latched into the attribute staging register.
REQ-019 Phase 2: TILEAD SHALL be driven to {staged tile, EY[2:0]} and held until the next phase 2.
REQ-020 Phase 3: TILEDT SHALL be latched into the pattern staging register.
REQ-021 Phase 7: both staging registers SHALL transfer into the shift/attribute registers at the clock edge.
REQ-022 Phases 4-6 SHALL be idle, and the staging registers SHALL hold their values.
REQ-023 The shift register SHALL shift by one pixel on every VCLK that is not a phase-7 load.
REQ-024 The emitted pixel SHALL be the MSB of each plane byte, as {planeP-1,...,plane0}.
REQ-025 OPIX SHALL be registered, with 1 VCLK latency: OPIX after the edge at HP=h SHALL be the pixel at screen column h.
REQ-026 The priority bit in OPIX SHALL be forced to 0 when the internal prio_en is 0; prio_en SHALL reset to PRIO_EN_DEF and SHALL be static otherwise.
REQ-027 Wrap-around: HP 511->0 and EX/NX overflow SHALL wrap silently, and col 31->0 SHALL fetch column 0 with no stall.
REQ-028 Reset mid-line: the shift register SHALL clear and output transparent pixels until the first phase-7 load following the first complete phase 0..3 fetch after reset release.
REQ-029 Simultaneous HP==0 and phase 7: the scroll capture and the tile load SHALL both occur on the same edge, and the load SHALL use the pre-capture staging contents.

Reset
REQ-030 On RESET=1 at a VCLK edge, OPIX, VRAMAD, TILEAD, the staging registers, the shift registers, SCRXr and SCRYr SHALL all become 0.
REQ-031 On RESET=1 at a VCLK edge, prio_en SHALL become PRIO_EN_DEF.
REQ-032 RESET SHALL take precedence over all other updates on the same edge.

Configuration
REQ-033 With macro BGLAYER_HFLIP_EN defined, a tile whose hflip bit is 1 SHALL be emitted from the LSB of each plane byte, and the shift direction SHALL reverse for that tile.
REQ-034 Without BGLAYER_HFLIP_EN, VRAMDT[11] SHALL be ignored and no hflip logic SHALL be synthesised.

Verification
REQ-035 SCRX=0, SCRY=0, VRAMDT=16'h9005, TILEDT plane0=8'h80, other planes 0 -> OPIX at HP=8 SHALL equal {1,3'b001,3'b001}, and at HP=9..15 the pixel field SHALL be 0.
REQ-036 SCRX=3 written at HP=100 -> no phase change on the current line, and from HP=0 of the next line VRAMAD SHALL update when (HP+3)[2:0]==0, i.e. at HP=5.
REQ-037 With BGLAYER_HFLIP_EN defined, VRAMDT bit11=1, plane0=8'h01 -> a pixel value of 1 SHALL appear at the tile's first column; without the macro it SHALL appear at the last column.
REQ-038 RESET asserted for 1 VCLK at HP=200 -> OPIX=0 through the first refill, and a valid pixel SHALL appear at the first tile boundary after a full fetch.
REQ-039 SCRY=505, VP=10 -> EY=3, so VRAMAD row SHALL be 0 and TILEAD line SHALL be 3.
REQ-040 PRIO_EN_DEF=0 with VRAMDT[15]=1 -> OPIX[MSB] SHALL stay 0.
